// File: rtl/instr_encoder_loader.sv
// Program loader: packs decoded instruction fields into 32-bit ARM-subset words
// and writes them to consecutive instruction-memory addresses. Optional macro: ENC_ILLEGAL_CHECK_EN.
module instr_encoder_loader #(
   parameter int ADDR_W    = 6,
   parameter int DEPTH     = 64,
   parameter int BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_last,
   input  logic [3:0]        in_cond,
   input  logic [1:0]        in_op,
   input  logic [5:0]        in_funct,
   input  logic [3:0]        in_rn,
   input  logic [3:0]        in_rd,
   input  logic [11:0]       in_src2,
   input  logic [23:0]       in_imm24,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic [ADDR_W:0]   count,
   output logic              busy,
   output logic              done,
   output logic              err
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCEPT,
      S_WRITE,
      S_DONE
   } state_t;

   localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);

   state_t              state, state_nx;
   logic [ADDR_W-1:0]   ptr;
   logic [ADDR_W:0]     cnt;
   logic [ADDR_W:0]     cnt_inc;
   logic [31:0]         word;
   logic [31:0]         enc_word;
   logic                last_r;
   logic                err_r;
   logic                hs;
   logic                illegal;
   logic                begin_session;

   assign hs            = in_valid && (state == S_ACCEPT);
   assign cnt_inc       = cnt + 1'b1;
   assign begin_session = start && ((state == S_IDLE) || (state == S_DONE));

   // Branches carry a 24-bit offset in place of funct[3:0]/Rn/Rd/Src2.
   always_comb begin
      // NOTE: assign a default before any conditional so no latch is inferred.
      enc_word = {in_cond, in_op, in_funct, in_rn, in_rd, in_src2};
      if (in_op == 2'b10)
         enc_word = {in_cond, 2'b10, in_funct[5:4], in_imm24};
   end

`ifdef ENC_ILLEGAL_CHECK_EN
   assign illegal = (in_op == 2'b11) || (in_cond == 4'hF) ||
                    ((in_op == 2'b01) && !in_funct[0] && (in_rd == 4'hF));
`else
   assign illegal = 1'b0;
`endif

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (reset) state <= S_IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:   if (start) state_nx = S_ACCEPT;
         S_ACCEPT: begin
            if (hs) begin
               if (!illegal)     state_nx = S_WRITE;
               else if (in_last) state_nx = S_DONE;
            end
         end
         S_WRITE:  state_nx = (last_r || (cnt_inc == DEPTH_C)) ? S_DONE : S_ACCEPT;
         S_DONE:   if (start) state_nx = S_ACCEPT;
         default:  state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr    <= BASE_C;
         cnt    <= '0;
         word   <= '0;
         last_r <= 1'b0;
         err_r  <= 1'b0;
      end else begin
         err_r <= 1'b0;
         if (begin_session) begin
            ptr <= BASE_C;
            cnt <= '0;
         end
         if (hs) begin
            last_r <= in_last;
            if (illegal) err_r <= 1'b1;
            else         word  <= enc_word;
         end
         if (state == S_WRITE) begin
            ptr <= ptr + 1'b1;
            cnt <= cnt_inc;
         end
         // Any bundle offered after the session closed is refused.
         if ((state == S_DONE) && in_valid && !start)
            err_r <= 1'b1;
      end
   end

   always_comb begin
      in_ready   = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      imem_we    = 1'b0;
      imem_addr  = '0;
      imem_wdata = '0;
      case (state)
         S_ACCEPT: begin
            in_ready = 1'b1;
            busy     = 1'b1;
         end
         S_WRITE: begin
            busy       = 1'b1;
            imem_we    = 1'b1;
            imem_addr  = ptr;
            imem_wdata = word;
         end
         S_DONE:   done = 1'b1;
         default:  ;
      endcase
   end

   assign count = cnt;
   assign err   = err_r;

endmodule
